// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and defaults for the otp bus owner arbiter and future TOP-level schedulers.
package bus_arb_pkg;

  localparam int NREQ_D    = 25;
  localparam int WIDTH_D   = 26;
  localparam int MAXHOLD_D = 16;
  localparam int IDXW_D    = 5;

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

  typedef struct packed {
    logic              found;
    logic [IDXW_D-1:0] idx;
  } pick_t;

  // Behavioural round-robin pick at the default sizes: first set bit from ptr upwards, wrapping.
  function automatic pick_t rr_pick(input logic [NREQ_D-1:0] req, input logic [IDXW_D-1:0] ptr);
    pick_t r;
    int    cand;
    r = '0;
    for (int i = NREQ_D - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NREQ_D;
      if (req[cand]) begin
        r.found = 1'b1;
        r.idx   = IDXW_D'(cand);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// Requester-side bundle of the shared otp bus: requests, data slices, grant and the muxed bus.
interface shared_bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int WIDTH = WIDTH_D,
  parameter int IDXW  = IDXW_D
);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       last;
  logic [NREQ*WIDTH-1:0] inp;
  logic [NREQ-1:0]       grant;
  logic [IDXW-1:0]       grant_idx;
  logic [0:WIDTH-1]      otp;
  logic                  otp_vld;
  logic                  forced;

  modport master (
    output req, last, inp,
    input  grant, grant_idx, otp, otp_vld, forced
  );

  modport slave (
    input  req, last, inp,
    output grant, grant_idx, otp, otp_vld, forced
  );

endinterface

// File: rtl/shared_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate by ptr, find lowest set bit, rotate the index back.
module rr_picker #(
  parameter int NREQ = 25,
  parameter int IDXW = 5
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            found_o,
  output logic [IDXW-1:0] idx_o
);

  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDXW-1:0]   off;
  logic [IDXW:0]     sum;

  assign dbl = {req_i, req_i};
  assign rot = dbl[ptr_i +: NREQ];

  // NOTE: every variable gets a default before the loop, so no path leaves it unassigned (no latch).
  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = IDXW'(i);
      end
    end
  end

  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= NREQ_W) ? IDXW'(sum - NREQ_W) : sum[IDXW-1:0];

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbiter for the shared otp bus: one owner at a time, hold limit, one dead
// turnaround cycle between owners, registered WIDTH-bit output mux.
module shared_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_D,
  parameter int WIDTH   = WIDTH_D,
  parameter int MAXHOLD = MAXHOLD_D,
  parameter int IDXW    = IDXW_D
) (
  input logic                 clk,
  input logic                 rst_n,
  shared_bus_arbiter_if.slave bus
);

  localparam int            HCW       = $clog2(MAXHOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAXHOLD - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HCW-1:0]    hold_q, hold_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   grant_idx_q, grant_idx_d;
  logic [WIDTH-1:0]  otp_q, otp_d;
  logic              otp_vld_q, otp_vld_d;
  logic              forced_q, forced_d;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic              owner_req, owner_last, at_limit, release_own;
  logic [WIDTH-1:0]  owner_data;

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // last only counts when the owner is still requesting.
  assign owner_req   = bus.req[grant_idx_q];
  assign owner_last  = bus.last[grant_idx_q] & owner_req;
  assign at_limit    = (hold_q == HOLD_LAST);
  assign release_own = !owner_req || owner_last || at_limit;

  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx_q == IDXW'(k)) owner_data = bus.inp[k*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = OWN;
      OWN:     if (release_own) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    otp_d       = '0;
    otp_vld_d   = 1'b0;
    forced_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = NREQ'(1) << pick_idx;
          grant_idx_d = pick_idx;
          rr_ptr_d    = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          hold_d      = '0;
        end
      end
      OWN: begin
        hold_d = at_limit ? hold_q : hold_q + 1'b1;
        // A dropped request aborts without capturing this cycle's beat.
        if (owner_req) begin
          otp_d     = owner_data;
          otp_vld_d = 1'b1;
        end
        if (release_own) begin
          grant_d     = '0;
          grant_idx_d = '0;
          forced_d    = at_limit && owner_req && !owner_last;
        end
      end
      default: begin
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      hold_q      <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      otp_q       <= '0;
      otp_vld_q   <= 1'b0;
      forced_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      otp_q       <= otp_d;
      otp_vld_q   <= otp_vld_d;
      forced_q    <= forced_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.otp       = otp_q;
  assign bus.otp_vld   = otp_vld_q;
  assign bus.forced    = forced_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed and random-soak bench for shared_bus_arbiter with continuous invariant monitoring.
module tb_shared_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int NREQ       = 25;
  localparam int WIDTH      = 26;
  localparam int MAXHOLD    = 16;
  localparam int IDXW       = 5;
  localparam int WAIT_BOUND = (NREQ - 1) * (MAXHOLD + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shared_bus_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  shared_bus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXHOLD(MAXHOLD), .IDXW(IDXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks     = 0;
  int errors     = 0;
  int inv_errors = 0;
  int max_wait   = 0;
  int wait_cnt [NREQ];
  bit fresh    [NREQ];
  logic [WIDTH-1:0] data [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Invariants plus wait tracking for requests raised while not owning.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      for (int k = 0; k < NREQ; k++) begin
        wait_cnt[k] = 0;
        fresh[k]    = 1'b1;
      end
    end else begin
      if (!$onehot0(bus.grant)) begin
        inv_errors++;
        $display("FAIL inv_onehot grant=%h", bus.grant);
      end
      if (!bus.otp_vld && bus.otp != '0) begin
        inv_errors++;
        $display("FAIL inv_otp_zero otp=%h", bus.otp);
      end
      if (dut.state_q != OWN && bus.grant != '0) begin
        inv_errors++;
        $display("FAIL inv_grant_state grant=%h", bus.grant);
      end
      if (bus.grant == '0 && bus.grant_idx != '0) begin
        inv_errors++;
        $display("FAIL inv_idx_zero grant_idx=%0d", bus.grant_idx);
      end
      for (int k = 0; k < NREQ; k++) begin
        if (!bus.req[k]) begin
          fresh[k]    = 1'b1;
          wait_cnt[k] = 0;
        end else if (bus.grant[k]) begin
          fresh[k]    = 1'b0;
          wait_cnt[k] = 0;
        end else if (fresh[k]) begin
          wait_cnt[k]++;
          if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.last = '0;
    bus.inp  = '0;
    for (int k = 0; k < NREQ; k++) begin
      data[k] = WIDTH'((k + 1) * 32'h0001_3579 ^ 32'h0155_0000);
    end
    data[3] = 26'h2AAAAAA;
    for (int k = 0; k < NREQ; k++) bus.inp[k*WIDTH +: WIDTH] = data[k];

    // Reset state
    step(); step();
    chk("rst_grant", bus.grant, 0);
    chk("rst_idx", bus.grant_idx, 0);
    chk("rst_otp", bus.otp, 0);
    chk("rst_vld", bus.otp_vld, 0);
    chk("rst_forced", bus.forced, 0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_grant", bus.grant, 0);
    chk("idle_vld", bus.otp_vld, 0);

    // Single owner, last on the 4th owned cycle
    bus.req[3] = 1'b1;
    step();
    chk("t2_idx", bus.grant_idx, 3);
    chk("t2_grant", bus.grant, 64'(1) << 3);
    chk("t2_vld0", bus.otp_vld, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) bus.last[3] = 1'b1;
      step();
      chk("t2_otp", bus.otp, data[3]);
      chk("t2_vld", bus.otp_vld, 1);
      chk("t2_grant_hold", bus.grant, (i < 4) ? (64'(1) << 3) : 64'(0));
      chk("t2_forced", bus.forced, 0);
    end
    bus.req[3]  = 1'b0;
    bus.last[3] = 1'b0;
    step();
    chk("t2_turn_vld", bus.otp_vld, 0);
    chk("t2_turn_otp", bus.otp, 0);
    chk("t2_turn_grant", bus.grant, 0);

    // rr_ptr is now 4: between 2 and 5, 5 wins
    bus.req[2] = 1'b1;
    bus.req[5] = 1'b1;
    step();
    chk("ptr_idx", bus.grant_idx, 5);
    step();
    chk("ptr_otp", bus.otp, data[5]);
    chk("ptr_vld", bus.otp_vld, 1);

    // Async reset mid-ownership
    rst_n = 1'b0;
    #1;
    chk("arst_grant", bus.grant, 0);
    chk("arst_idx", bus.grant_idx, 0);
    chk("arst_otp", bus.otp, 0);
    chk("arst_vld", bus.otp_vld, 0);
    bus.req = '0;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_grant", bus.grant, 0);
    chk("post_rst_vld", bus.otp_vld, 0);

    // Round-robin: everyone requesting, last on every first beat
    bus.req  = '1;
    bus.last = '1;
    for (int n = 0; n <= NREQ; n++) begin
      step();
      chk("rr_idx", bus.grant_idx, n % NREQ);
      chk("rr_grant", bus.grant, 64'(1) << (n % NREQ));
      step();
      chk("rr_release", bus.grant, 0);
      chk("rr_otp", bus.otp, data[n % NREQ]);
      chk("rr_vld", bus.otp_vld, 1);
      chk("rr_forced", bus.forced, 0);
      step();
      chk("rr_gap_vld", bus.otp_vld, 0);
      chk("rr_gap_grant", bus.grant, 0);
      if (n == NREQ) begin
        bus.req  = '0;
        bus.last = '0;
      end
    end

    // Hold limit on requester 24 (rr_ptr is 1)
    bus.req[24] = 1'b1;
    step();
    chk("hold_idx", bus.grant_idx, 24);
    for (int i = 1; i <= MAXHOLD; i++) begin
      step();
      chk("hold_otp", bus.otp, data[24]);
      chk("hold_vld", bus.otp_vld, 1);
      chk("hold_grant", bus.grant, (i < MAXHOLD) ? (64'(1) << 24) : 64'(0));
      chk("hold_forced", bus.forced, (i == MAXHOLD));
    end
    step();
    chk("hold_forced_end", bus.forced, 0);
    chk("hold_turn_vld", bus.otp_vld, 0);
    step();
    chk("hold_regrant", bus.grant_idx, 24);

    // Abort: owner drops req after one beat
    step();
    chk("abort_beat", bus.otp, data[24]);
    bus.req[24] = 1'b0;
    step();
    chk("abort_grant", bus.grant, 0);
    chk("abort_vld", bus.otp_vld, 0);
    chk("abort_otp", bus.otp, 0);
    chk("abort_forced", bus.forced, 0);

    // last coinciding with the hold limit (rr_ptr is 0)
    bus.req[7] = 1'b1;
    step();
    chk("sim_turn_grant", bus.grant, 0);
    step();
    chk("sim_idx", bus.grant_idx, 7);
    for (int i = 1; i <= MAXHOLD; i++) begin
      if (i == MAXHOLD) bus.last[7] = 1'b1;
      step();
      chk("sim_otp", bus.otp, data[7]);
      chk("sim_vld", bus.otp_vld, 1);
      chk("sim_grant", bus.grant, (i < MAXHOLD) ? (64'(1) << 7) : 64'(0));
      chk("sim_forced", bus.forced, 0);
    end
    bus.req[7]  = 1'b0;
    bus.last[7] = 1'b0;
    step();
    chk("sim_end_vld", bus.otp_vld, 0);

    // Random soak: waiting requesters hold req, owners may drop it
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.grant[k]) begin
          if ($urandom_range(3) == 0) bus.req[k] = 1'b0;
        end else if (!bus.req[k] && $urandom_range(7) == 0) begin
          bus.req[k] = 1'b1;
        end
        bus.last[k] = ($urandom_range(5) == 0);
      end
      step();
    end
    bus.req  = '0;
    bus.last = '0;
    step(); step(); step(); step();
    chk("soak_idle_grant", bus.grant, 0);
    chk("soak_idle_vld", bus.otp_vld, 0);
    chk("invariants", inv_errors, 0);
    // Counted from the sample before the first edge that sees the request, hence +1.
    chk("wait_bound", (max_wait <= WAIT_BOUND + 1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
